// File: rtl/bz_seq_pkg.sv
// rtl/bz_seq_pkg.sv - shared types and constants for the buzzer melody sequencer
package bz_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_HOLD,
      ST_GAP
   } state_t;

   localparam int DUR_MSB   = 7;
   localparam int DUR_LSB   = 4;
   localparam int PITCH_MSB = 3;
   localparam int PITCH_LSB = 0;

   localparam logic [3:0] REST   = 4'h0;
   localparam logic [7:0] SILENT = 8'h00;

   localparam int TICK_DEFAULT = 1000000;
   localparam int GAP_DEFAULT  = 200000;

   function automatic logic [3:0] note_dur(input logic [7:0] note);
      return note[DUR_MSB:DUR_LSB];
   endfunction

endpackage

// File: rtl/bz_sequencer_if.sv
// rtl/bz_sequencer_if.sv - host/keypad and io_bz facing signals of the sequencer
interface bz_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] len;
   logic          loop;
   logic          play;
   logic          stop;
   logic          bz_start;
   logic [7:0]    bz_val;
   logic          busy;
   logic [AW-1:0] note_idx;
   logic          done;

   modport master (
      output wr_en, wr_addr, wr_data, len, loop, play, stop,
      input  bz_start, bz_val, busy, note_idx, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, len, loop, play, stop,
      output bz_start, bz_val, busy, note_idx, done
   );

endinterface

// File: rtl/seq_tick.sv
// rtl/seq_tick.sv - duration prescaler, one-cycle pulse every TICK cycles
module seq_tick
   import bz_seq_pkg::*;
#(
   parameter int TICK = TICK_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/bz_sequencer.sv
// rtl/bz_sequencer.sv - melody sequencer: note table, playback FSM, io_bz start/val drive
module bz_sequencer
   import bz_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TICK  = TICK_DEFAULT,
   parameter int GAP   = GAP_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   bz_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   state_t        state, next_state;
   logic [7:0]    tbl [DEPTH];
   logic [AW-1:0] idx, len_q;
   logic [7:0]    val;
   logic [3:0]    units;
   logic [GW-1:0] gap_cnt;
   logic          start_q, done_q;
   logic          tick, hold_end, gap_end, last_note, abort;

   seq_tick #(.TICK(TICK)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != ST_HOLD),
      .tick (tick)
   );

   assign abort     = bus.stop && (state != ST_IDLE);
   assign hold_end  = (state == ST_HOLD) && tick && (units == note_dur(val));
   assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_LAST);
   assign last_note = (idx == len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:  if (bus.play && !bus.stop) next_state = ST_LOAD;
         ST_LOAD:  next_state = ST_START;
         ST_START: next_state = ST_HOLD;
         ST_HOLD:  if (hold_end) next_state = ST_GAP;
         ST_GAP:   if (gap_end) next_state = (!last_note || bus.loop) ? ST_LOAD : ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      if (abort) next_state = ST_IDLE;
   end

   // Table read in LOAD uses the pre-write value when a write hits the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= 8'h00;
         idx     <= '0;
         len_q   <= '0;
         val     <= SILENT;
         units   <= '0;
         gap_cnt <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (bus.wr_en) tbl[bus.wr_addr] <= bus.wr_data;
         start_q <= (next_state == ST_START);
         done_q  <= 1'b0;
         units   <= (state == ST_HOLD) ? (tick ? units + 4'd1 : units) : 4'd0;
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;

         if (state == ST_IDLE && next_state == ST_LOAD) begin
            idx   <= '0;
            len_q <= bus.len;
         end
         if (state == ST_LOAD) val <= tbl[idx];

         if (gap_end && !abort) begin
            if (!last_note) begin
               idx <= idx + 1'b1;
            end else if (bus.loop) begin
               idx   <= '0;
               len_q <= bus.len;
            end else begin
               done_q <= 1'b1;
               val    <= SILENT;
            end
         end

         // Abort silences the pitch at once rather than waiting for the gap.
         if (abort) val <= SILENT;
      end
   end

   assign bus.bz_start = start_q;
   assign bus.bz_val   = val;
   assign bus.busy     = (state != ST_IDLE);
   assign bus.note_idx = idx;
   assign bus.done     = done_q;

endmodule

// File: doc/bz_sequencer.md
Name: bz_sequencer

Overview:
Melody sequencer that drives the buzzer controller (io_bz) through its start/val inputs. It holds a small note table written by the host (CPU or keypad logic) and plays entries 0..len in order. For each note it pulses start, holds the note for its duration, then inserts a silent gap. Supports one-shot or looped playback, with stop at any time; sits between the register/keypad logic and io_bz.

Parameters:
DEPTH, 16, note-table entries; power of two, 2..16
TICK, 1000000, clock cycles per duration unit (0.1 s, matches io_bz duration unit)
GAP, 200000, silent cycles after each note; must be >= 4 so io_bz's enable has expired

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  note-table write strobe
wr_addr  in  $clog2(DEPTH)  write index
wr_data  in  8  note {dur[7:4], pitch[3:0]}, same encoding as io_bz val
len  in  $clog2(DEPTH)  index of last note played (sampled at play and at each wrap)
loop  in  1  level; 1 = restart at index 0 after last note
play  in  1  single-cycle start command
stop  in  1  single-cycle abort command
bz_start  out  1  one-cycle pulse to io_bz start
bz_val  out  8  note value to io_bz val
busy  out  1  high in any state other than IDLE
note_idx  out  $clog2(DEPTH)  index of note currently playing
done  out  1  one-cycle pulse on normal (non-stop) completion

Behaviour:
- Everything is synchronous to clk. Reset is sampled on rising clk with rst=1 and takes priority over all other inputs.
- Reset values: state IDLE; bz_start 0; bz_val 8'h00; busy 0; note_idx 0; done 0; all table entries 8'h00; latched len 0.
- States:
  - IDLE -> LOAD on play=1 && stop=0. In that cycle note_idx<=0 and len is latched.
  - LOAD (1 cycle): bz_val <= table[note_idx].
  - START (1 cycle): bz_start=1.
  - HOLD: lasts (dur+1)*TICK cycles, where dur = bz_val[7:4].
  - GAP: lasts GAP cycles.
- At the end of the last GAP cycle:
  - if note_idx != latched len: note_idx+1, go to LOAD;
  - else if loop=1: note_idx<=0, re-latch len, go to LOAD;
  - else go to IDLE with done=1 and bz_val<=8'h00.
- Timing: bz_start is registered high only in START. Start-to-start interval is (dur+1)*TICK + GAP + 2 cycles. done is high in the first IDLE cycle, (dur+1)*TICK + GAP + 1 cycles after the last bz_start cycle.
- Duration timing uses no multiplier: a prescaler counts TICK cycles and a 4-bit unit counter counts 0..dur. Both clear on entry to HOLD.
- bz_val holds through HOLD and GAP. Pitch 0 (rest) is played like any note: start is pulsed and timing is identical.
- stop=1 while busy: next cycle state IDLE, bz_val=8'h00 (silences io_bz pitch immediately), bz_start=0, busy=0, done stays 0.
- stop=1 in IDLE has no effect. play and stop in the same IDLE cycle: stop wins, state stays IDLE.
- play while busy is ignored. It does not restart playback.
- Table writes are accepted in every state. A write and a LOAD to the same address in the same cycle: LOAD takes the old value and the write lands afterwards.
- len and loop changes mid-play: len takes effect only at play or at wrap; loop is sampled at the end of the last note.
- Indices wrap naturally within the $clog2(DEPTH) width. len >= DEPTH cannot be encoded.

Decomposition:
- Shared package bz_seq_pkg:
  - state encoding (IDLE, LOAD, START, HOLD, GAP);
  - note field positions (DUR_MSB=7, DUR_LSB=4, PITCH_MSB=3, PITCH_LSB=0);
  - REST pitch constant 4'h0;
  - default TICK and GAP values.
- One sub-module, seq_tick: prescaler with synchronous clear, emitting a one-cycle pulse every TICK cycles.
- The FSM, note table and unit counter stay in bz_sequencer.

Test Plan (TICK=10, GAP=4):
1. Assert rst for 2 cycles mid-HOLD -> next cycle bz_start=0, bz_val=00, busy=0, done=0, note_idx=0; reading entry 0 by playing gives bz_val=00.
2. Write table[0]=8'h21, table[1]=8'h05, len=1, loop=0, pulse play -> bz_start with bz_val=21, next bz_start 36 cycles later with bz_val=05, done 15 cycles after that, bz_val returns to 00.
3. table[0]=8'h13, len=0, loop=1, play -> bz_start every 26 cycles, note_idx stays 0, done never asserted; drop loop -> done after current note.
4. Play a 3-note table; stop 5 cycles into HOLD of note 1 -> next cycle busy=0, bz_val=00; no further bz_start; no done.
5. Pulse play while busy -> start times unchanged. play+stop in the same IDLE cycle -> busy stays 0.
6. During note 0 HOLD, write table[1]=8'h37 -> note 1 plays with bz_val=37. A write to table[k] in the same cycle as LOAD of k -> the old value plays.
